uart_mem_dump: RTL

Memory read-back transmitter for the 8-bit computer's serial link. It is the outbound counterpart to the UART programming path, which writes received bytes into the 16-entry program RAM. On a start pulse, this block walks all 16 RAM addresses, reads each byte and serializes a framed dump onto the UART TX line (8N1, LSB first). The host can then verify what was loaded.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_mem_dump_if.sv | 12 +
 rtl/uart_tx_core.sv | 81 ++++++++
 rtl/uart_mem_dump.sv | 99 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state type for the memory dump transmitter
package uart_pkg;

    localparam logic [7:0] DUMP_HEADER     = 8'hA5;
    localparam int         UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        CSUM,
        FINISH
    } dump_state_e;

endpackage

// File: rtl/uart_mem_dump_if.sv
// rtl/uart_mem_dump_if.sv - program RAM read port between the dump engine and the RAM
interface uart_mem_dump_if #(
    parameter int ADDR_W = 4
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (output mem_addr, input mem_data);
    modport slave  (input mem_addr, output mem_data);

endinterface

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8N1 byte serializer, LSB first, registered line output
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       ready,
    output logic       txd
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       STOP_IDX = 4'(UART_FRAME_BITS - 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             txd_q, txd_d;
    logic             bit_end;

    assign bit_end = active_q && (cnt_q == CNT_LAST);
    // Asserted in the final stop-bit cycle so the next start bit follows with no gap.
    assign ready   = !active_q || (bit_end && (bit_idx_q == STOP_IDX));
    assign txd     = txd_q;

    always_comb begin
        active_d  = active_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        txd_d     = txd_q;
        if (load && ready) begin
            active_d  = 1'b1;
            cnt_d     = '0;
            bit_idx_d = '0;
            shreg_d   = byte_in;
            txd_d     = 1'b0;
        end else if (active_q) begin
            if (bit_end) begin
                cnt_d = '0;
                if (bit_idx_q == STOP_IDX) begin
                    active_d  = 1'b0;
                    bit_idx_d = '0;
                    txd_d     = 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q < STOP_IDX - 4'd1) begin
                        txd_d   = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end else begin
                        txd_d = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: rtl/uart_mem_dump.sv
// rtl/uart_mem_dump.sv - walks the program RAM and sends header, contents and checksum over UART
module uart_mem_dump
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int ADDR_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    uart_mem_dump_if.master         mem,
    output logic                    uart_txd,
    output logic                    busy,
    output logic                    done
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        csum_q, csum_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tx_load;
    logic [7:0]        tx_byte;
    logic              tx_ready;

    assign mem.mem_addr = mem_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        csum_d     = csum_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_load    = 1'b0;
        tx_byte    = 8'h00;
        case (state_q)
            IDLE: begin
                csum_d = 8'h00;
                // A start coinciding with the done pulse belongs to the old dump.
                if (start && !done_q) state_d = HEADER;
            end
            HEADER: if (tx_ready) begin
                tx_load    = 1'b1;
                tx_byte    = DUMP_HEADER;
                mem_addr_d = '0;
                busy_d     = 1'b1;
                state_d    = DATA;
            end
            DATA: if (tx_ready) begin
                tx_load    = 1'b1;
                tx_byte    = mem.mem_data;
                csum_d     = csum_q + mem.mem_data;
                mem_addr_d = mem_addr_q + 1'b1;
                if (&mem_addr_q) state_d = CSUM;
            end
            CSUM: if (tx_ready) begin
                tx_load = 1'b1;
                tx_byte = csum_q;
                state_d = FINISH;
            end
            FINISH: if (tx_ready) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            csum_q     <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            csum_q     <= csum_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tx_load),
        .byte_in(tx_byte),
        .ready  (tx_ready),
        .txd    (uart_txd)
    );

endmodule
